tt_sel_driver: RTL and testbench

TT_SEL_DRIVER -- requirements
Module: tt_sel_driver

---
 rtl/tt_pkg.sv | 21 ++
 rtl/tt_pulse_timer.sv | 46 ++++
 rtl/tt_sel_driver.sv | 142 ++++++++++++++
 tb/tb_tt_sel_driver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the TinyTapeout design-select driver.
//   sel_state_e : sequencing states of the select driver FSM
//   ADDR_W_DEF  : default width of the design address
//   PULSE_W_DEF : default number of cycles each control-pulse phase is held
//   PHASE_CNT_W : width of the phase counter (covers PULSE_W up to 255)
package tt_pkg;

   localparam int unsigned ADDR_W_DEF  = 10;
   localparam int unsigned PULSE_W_DEF = 4;
   localparam int unsigned PHASE_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      GAP    = 3'd2,
      INC_HI = 3'd3,
      INC_LO = 3'd4,
      ENA    = 3'd5
   } sel_state_e;

endpackage

// File: rtl/tt_pulse_timer.sv
// Phase timer for the select driver.
// The count restarts at zero whenever the FSM changes state, so every phase
// is measured from its own first cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   load   : FSM is changing state this cycle; restart the count
//   expire : current phase has been held for PULSE_W cycles
module tt_pulse_timer
   import tt_pkg::*;
#(
   parameter int unsigned PULSE_W = PULSE_W_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   localparam logic [PHASE_CNT_W-1:0] LAST_CNT = PHASE_CNT_W'(PULSE_W - 1);

   logic [PHASE_CNT_W-1:0] cnt_q;
   logic [PHASE_CNT_W-1:0] cnt_d;

   // Saturate instead of wrapping so a long IDLE stretch never aliases
   // back onto the expire value.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == LAST_CNT);

endmodule

// File: rtl/tt_sel_driver.sv
// Drives the TinyTapeout mux controller to select one user design:
// pulse the select-counter reset, then pulse the increment addr times,
// then raise the enable. All outputs are registered.
// Optional feature: define TT_SEL_ABORT_EN to add the abort input, which
// returns a busy driver to IDLE with the enable low and no done pulse.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   abort          : (TT_SEL_ABORT_EN only) cancel the running sequence
//   req_valid      : a select request is offered
//   req_addr       : index of the design to select
//   req_ready      : driver is IDLE and will accept a request
//   busy           : a sequence is running
//   done           : one-cycle pulse when a selection completes
//   ctrl_sel_rst_n : mux controller select-counter reset, active-low
//   ctrl_sel_inc   : mux controller select-counter increment
//   ctrl_ena       : mux controller enable for the selected design
module tt_sel_driver
   import tt_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned PULSE_W = PULSE_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
`ifdef TT_SEL_ABORT_EN
   input  logic              abort,
`endif
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              busy,
   output logic              done,
   output logic              ctrl_sel_rst_n,
   output logic              ctrl_sel_inc,
   output logic              ctrl_ena
);

   sel_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] inc_cnt_q, inc_cnt_d;
   logic [ADDR_W-1:0] inc_next;
   logic              req_ready_q, req_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ctrl_sel_rst_n_q, ctrl_sel_rst_n_d;
   logic              ctrl_sel_inc_q, ctrl_sel_inc_d;
   logic              ctrl_ena_q, ctrl_ena_d;
   logic              kill;
   logic              phase_load;
   logic              phase_expire;

   assign phase_load = (state_d != state_q);

   tt_pulse_timer #(
      .PULSE_W (PULSE_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (phase_load),
      .expire (phase_expire)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      inc_cnt_d = inc_cnt_q;
      inc_next  = inc_cnt_q + 1'b1;
      kill      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d   = RST;
               addr_d    = req_addr;
               inc_cnt_d = '0;
            end
         end
         RST:    if (phase_expire) state_d = GAP;
         GAP:    if (phase_expire) state_d = (addr_q == '0) ? ENA : INC_HI;
         INC_HI: if (phase_expire) state_d = INC_LO;
         INC_LO: begin
            // inc_next never exceeds addr_q, so the counter cannot wrap.
            if (phase_expire) begin
               inc_cnt_d = inc_next;
               state_d   = (inc_next < addr_q) ? INC_HI : ENA;
            end
         end
         ENA:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef TT_SEL_ABORT_EN
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         kill    = 1'b1;
      end
`endif

      // Outputs follow the next state so they are registered yet aligned
      // with the state they describe.
      req_ready_d      = (state_d == IDLE);
      busy_d           = (state_d != IDLE);
      done_d           = (state_d == ENA);
      ctrl_sel_rst_n_d = (state_d != RST);
      ctrl_sel_inc_d   = (state_d == INC_HI);
      // The enable survives into IDLE after a completed selection and is
      // dropped by the next RST or by an abort.
      ctrl_ena_d       = (state_d == ENA) ||
                         ((state_d == IDLE) && ctrl_ena_q && !kill);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         req_ready_q      <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         ctrl_sel_rst_n_q <= 1'b0;
         ctrl_sel_inc_q   <= 1'b0;
         ctrl_ena_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         req_ready_q      <= req_ready_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         ctrl_sel_rst_n_q <= ctrl_sel_rst_n_d;
         ctrl_sel_inc_q   <= ctrl_sel_inc_d;
         ctrl_ena_q       <= ctrl_ena_d;
      end
      addr_q    <= addr_d;
      inc_cnt_q <= inc_cnt_d;
   end

   assign req_ready      = req_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign ctrl_sel_rst_n = ctrl_sel_rst_n_q;
   assign ctrl_sel_inc   = ctrl_sel_inc_q;
   assign ctrl_ena       = ctrl_ena_q;

endmodule

// File: tb/tb_tt_sel_driver.sv
// Directed bench for tt_sel_driver: one instance with PULSE_W=4 and one
// with PULSE_W=2, both ADDR_W=10. Define TT_SEL_ABORT_EN to also exercise
// the abort input.
module tb_tt_sel_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // PULSE_W = 4 instance
   logic       r4_rst_n = 1'b0;
   logic       r4_valid = 1'b0;
   logic [9:0] r4_addr  = '0;
   logic       abort4   = 1'b0;
   logic o4_ready, o4_busy, o4_done, o4_srst_n, o4_inc, o4_ena;

   // PULSE_W = 2 instance
   logic       r2_rst_n = 1'b0;
   logic       r2_valid = 1'b0;
   logic [9:0] r2_addr  = '0;
   logic       abort2   = 1'b0;
   logic o2_ready, o2_busy, o2_done, o2_srst_n, o2_inc, o2_ena;

   tt_sel_driver #(.ADDR_W(10), .PULSE_W(4)) u4 (
      .clk            (clk),
      .rst_n          (r4_rst_n),
`ifdef TT_SEL_ABORT_EN
      .abort          (abort4),
`endif
      .req_valid      (r4_valid),
      .req_addr       (r4_addr),
      .req_ready      (o4_ready),
      .busy           (o4_busy),
      .done           (o4_done),
      .ctrl_sel_rst_n (o4_srst_n),
      .ctrl_sel_inc   (o4_inc),
      .ctrl_ena       (o4_ena)
   );

   tt_sel_driver #(.ADDR_W(10), .PULSE_W(2)) u2 (
      .clk            (clk),
      .rst_n          (r2_rst_n),
`ifdef TT_SEL_ABORT_EN
      .abort          (abort2),
`endif
      .req_valid      (r2_valid),
      .req_addr       (r2_addr),
      .req_ready      (o2_ready),
      .busy           (o2_busy),
      .done           (o2_done),
      .ctrl_sel_rst_n (o2_srst_n),
      .ctrl_sel_inc   (o2_inc),
      .ctrl_ena       (o2_ena)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples one instance at each falling edge from the cycle after the
   // accepting edge (k=0) until done is seen or the budget runs out.
   task automatic watch(input bit sel2, input int budget,
                        output int done_at, output int rst_lo, output int rises,
                        output int hi_cyc, output int rdy_hi);
      logic p_inc;
      logic d, r, i, rdy;
      p_inc   = 1'b0;
      done_at = -1;
      rst_lo  = 0;
      rises   = 0;
      hi_cyc  = 0;
      rdy_hi  = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         d   = sel2 ? o2_done   : o4_done;
         r   = sel2 ? o2_srst_n : o4_srst_n;
         i   = sel2 ? o2_inc    : o4_inc;
         rdy = sel2 ? o2_ready  : o4_ready;
         if (!r) rst_lo++;
         if (i) hi_cyc++;
         if (i && !p_inc) rises++;
         p_inc = i;
         if (rdy) rdy_hi++;
         if (d) begin
            done_at = k;
            break;
         end
      end
   endtask

   initial begin
      int done_at, rst_lo, rises, hi_cyc, rdy_hi;
      bit reached;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ready4", o4_ready, 0);
      chk("rst_busy4",  o4_busy,  0);
      chk("rst_done4",  o4_done,  0);
      chk("rst_srst4",  o4_srst_n, 0);
      chk("rst_inc4",   o4_inc,   0);
      chk("rst_ena4",   o4_ena,   0);
      chk("rst_srst2",  o2_srst_n, 0);
      chk("rst_ready2", o2_ready, 0);

      // First cycle after reset release
      r4_rst_n = 1'b1;
      r2_rst_n = 1'b1;
      @(negedge clk);
      chk("rel_srst4",  o4_srst_n, 1);
      chk("rel_ready4", o4_ready, 1);
      chk("rel_ena4",   o4_ena,   0);
      chk("rel_busy4",  o4_busy,  0);
      chk("rel_ready2", o2_ready, 1);

      // addr 0, PULSE_W 4: RST 4 + GAP 4, no increments
      r4_valid = 1'b1;
      r4_addr  = 10'd0;
      watch(1'b0, 50, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      r4_valid = 1'b0;
      chk("a0_done_at", done_at, 8);
      chk("a0_rst_lo",  rst_lo, 4);
      chk("a0_rises",   rises, 0);
      chk("a0_rdy_busy", rdy_hi, 0);
      chk("a0_ena_done", o4_ena, 1);
      @(negedge clk);
      chk("a0_done_1cyc", o4_done, 0);
      chk("a0_idle_ena",  o4_ena, 1);
      chk("a0_idle_rdy",  o4_ready, 1);
      chk("a0_idle_busy", o4_busy, 0);
      repeat (2) @(negedge clk);
      chk("a0_ena_hold", o4_ena, 1);

      // addr 5, PULSE_W 2: 2 + 2 + 5*4 = 24
      r2_valid = 1'b1;
      r2_addr  = 10'd5;
      watch(1'b1, 100, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      r2_valid = 1'b0;
      chk("a5_done_at", done_at, 24);
      chk("a5_rst_lo",  rst_lo, 2);
      chk("a5_rises",   rises, 5);
      chk("a5_hi_cyc",  hi_cyc, 10);
      @(negedge clk);
      chk("a5_ena", o2_ena, 1);
      chk("a5_done_1cyc", o2_done, 0);

      // addr 1023, PULSE_W 2: 2 + 2 + 1023*4 = 4096
      r2_valid = 1'b1;
      r2_addr  = 10'd1023;
      watch(1'b1, 5000, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      r2_valid = 1'b0;
      chk("a1023_done_at", done_at, 4096);
      chk("a1023_rises",   rises, 1023);
      chk("a1023_hi_cyc",  hi_cyc, 2046);
      @(negedge clk);
      chk("a1023_ena",  o2_ena, 1);
      chk("a1023_done_once", o2_done, 0);

      // Request held with a changing address: only addr 2 is used.
      // The address changes one cycle after accept, so counts start at k=1.
      r4_valid = 1'b1;
      r4_addr  = 10'd2;
      @(negedge clk);
      chk("hold_rdy_k0", o4_ready, 0);
      r4_addr  = 10'd6;
      watch(1'b0, 100, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      r4_valid = 1'b0;
      chk("hold_done_at", done_at, 23);
      chk("hold_rises",   rises, 2);
      chk("hold_rdy_busy", rdy_hi, 0);
      chk("hold_rst_lo",  rst_lo, 3);
      @(negedge clk);
      chk("hold_idle_ena", o4_ena, 1);
      chk("hold_idle_rdy", o4_ready, 1);

      // Back-to-back request in the IDLE cycle after done drops ctrl_ena
      r4_valid = 1'b1;
      r4_addr  = 10'd1;
      @(negedge clk);
      r4_valid = 1'b0;
      chk("b2b_ena_drop", o4_ena, 0);
      chk("b2b_busy",     o4_busy, 1);
      watch(1'b0, 100, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      chk("b2b_done_at", done_at, 15);
      chk("b2b_rises",   rises, 1);
      @(negedge clk);
      chk("b2b_ena", o4_ena, 1);

`ifdef TT_SEL_ABORT_EN
      // abort in IDLE has no effect
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      chk("abidle_ena", o4_ena, 1);
      chk("abidle_rdy", o4_ready, 1);
      chk("abidle_busy", o4_busy, 0);

      // abort during GAP (k=4 with PULSE_W 4)
      r4_valid = 1'b1;
      r4_addr  = 10'd3;
      @(negedge clk);
      r4_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("abgap_in_gap", o4_srst_n, 1);
      chk("abgap_busy_pre", o4_busy, 1);
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      chk("abgap_busy", o4_busy, 0);
      chk("abgap_ena",  o4_ena, 0);
      chk("abgap_done", o4_done, 0);
      chk("abgap_srst", o4_srst_n, 1);
      chk("abgap_inc",  o4_inc, 0);
      chk("abgap_rdy",  o4_ready, 1);
      r4_valid = 1'b1;
      r4_addr  = 10'd1;
      watch(1'b0, 100, done_at, rst_lo, rises, hi_cyc, rdy_hi);
      r4_valid = 1'b0;
      chk("abnew_done_at", done_at, 16);
      chk("abnew_rises",   rises, 1);
      chk("abnew_ena",     o4_ena, 1);
`endif

      // Reset during INC_HI of pulse 3 on the PULSE_W 2 instance
      r2_valid = 1'b1;
      r2_addr  = 10'd5;
      reached  = 1'b0;
      begin
         logic p;
         int   n;
         p = 1'b0;
         n = 0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) r2_valid = 1'b0;
            if (o2_inc && !p) n++;
            p = o2_inc;
            if (n == 3) begin
               reached = 1'b1;
               break;
            end
         end
      end
      chk("mid_reached_p3", reached, 1);
      chk("mid_ena_pre", o2_ena, 0);
      r2_rst_n = 1'b0;
      @(negedge clk);
      chk("mid_inc",  o2_inc, 0);
      chk("mid_srst", o2_srst_n, 0);
      chk("mid_ena",  o2_ena, 0);
      chk("mid_done", o2_done, 0);
      chk("mid_busy", o2_busy, 0);
      chk("mid_rdy",  o2_ready, 0);
      @(negedge clk);
      chk("mid_done2", o2_done, 0);
      r2_rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_srst", o2_srst_n, 1);
      chk("mid_rel_rdy",  o2_ready, 1);
      chk("mid_rel_ena",  o2_ena, 0);
      chk("mid_rel_done", o2_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
